// File: rtl/gmii_link_pkg.sv
// rtl/gmii_link_pkg.sv - shared types and constants for the GMII link-partner transmitter
// State encoding, preamble bytes and CRC-32 constants.
package gmii_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_PAYLOAD,
      ST_PAD,
      ST_FCS,
      ST_IFG,
      ST_DRAIN
   } state_e;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam int          PREAMBLE_LEN  = 7;

   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// rtl/crc32_byte_step.sv - combinational one-byte update of a reflected CRC-32
// Bits are consumed LSB first, matching Ethernet bit order on the wire.
module crc32_byte_step
   import gmii_link_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

   logic [31:0] c;

   always_comb begin
      c = crc_i ^ {24'h000000, data_i};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
      end
   end

   assign crc_o = c;

endmodule

// File: rtl/gmii_link_partner_tx.sv
// rtl/gmii_link_partner_tx.sv - AXI-Stream byte frames to GMII transmit with preamble, pad, FCS and IFG
// Optional FCS error injection is enabled by defining GMII_LINK_PARTNER_FCS_ERR_INJECT_EN.
module gmii_link_partner_tx
   import gmii_link_pkg::*;
#(
   parameter int ENABLE_PADDING   = 1,
   parameter int MIN_FRAME_LENGTH = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
`ifdef GMII_LINK_PARTNER_FCS_ERR_INJECT_EN
   input  logic       inject_fcs_err,
`endif
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   input  logic [7:0] ifg_delay,
   output logic       status_frame_sent,
   output logic       status_underflow
);

   localparam logic [15:0] PAD_TARGET = 16'(MIN_FRAME_LENGTH - 4);

   state_e      state_q;
   logic [2:0]  pre_cnt_q;
   logic [15:0] byte_cnt_q;
   logic [1:0]  fcs_idx_q;
   logic [7:0]  ifg_cnt_q;
   logic [31:0] crc_q;
   logic        tready_q;
   logic [7:0]  txd_q;
   logic        tx_en_q;
   logic        tx_er_q;
   logic        sent_q;
   logic        uf_q;

   logic [15:0] byte_cnt_d;
   logic [31:0] crc_d;
   logic [7:0]  crc_data;
   logic [7:0]  ifg_load_d;
   logic [31:0] fcs_word;
   logic [7:0]  fcs_byte;
   logic        fcs_flip;
   logic        accept_last;

   assign accept_last = (state_q == ST_PAYLOAD) && s_axis_tvalid && tready_q && s_axis_tlast;

`ifdef GMII_LINK_PARTNER_FCS_ERR_INJECT_EN
   logic inject_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inject_q <= 1'b0;
      end else if (accept_last) begin
         inject_q <= inject_fcs_err;
      end
   end

   assign fcs_flip = inject_q && (fcs_idx_q == 2'd0);
`else
   assign fcs_flip = 1'b0;
`endif

   // Pad bytes are zeros that still feed the CRC.
   assign crc_data   = (state_q == ST_PAD) ? 8'h00 : s_axis_tdata;
   assign byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
   assign ifg_load_d = (ifg_delay == 8'd0) ? 8'd1 : ifg_delay;
   assign fcs_word   = ~crc_q;

   crc32_byte_step u_crc (
      .crc_i  (crc_q),
      .data_i (crc_data),
      .crc_o  (crc_d)
   );

   always_comb begin
      fcs_byte = 8'h00;
      case (fcs_idx_q)
         2'd0: fcs_byte = fcs_word[7:0];
         2'd1: fcs_byte = fcs_word[15:8];
         2'd2: fcs_byte = fcs_word[23:16];
         2'd3: fcs_byte = fcs_word[31:24];
         default: fcs_byte = 8'h00;
      endcase
      fcs_byte = fcs_byte ^ {8{fcs_flip}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pre_cnt_q  <= 3'd0;
         byte_cnt_q <= 16'd0;
         fcs_idx_q  <= 2'd0;
         ifg_cnt_q  <= 8'd0;
         crc_q      <= CRC32_INIT;
         tready_q   <= 1'b0;
         txd_q      <= 8'h00;
         tx_en_q    <= 1'b0;
         tx_er_q    <= 1'b0;
         sent_q     <= 1'b0;
         uf_q       <= 1'b0;
      end else begin
         tx_er_q <= 1'b0;
         sent_q  <= 1'b0;
         uf_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tx_en_q  <= 1'b0;
               txd_q    <= 8'h00;
               tready_q <= 1'b0;
               if (s_axis_tvalid) begin
                  state_q    <= ST_PREAMBLE;
                  tx_en_q    <= 1'b1;
                  txd_q      <= PREAMBLE_BYTE;
                  pre_cnt_q  <= 3'd1;
                  byte_cnt_q <= 16'd0;
                  crc_q      <= CRC32_INIT;
               end
            end
            ST_PREAMBLE: begin
               // tready rises together with the SFD so payload follows it back to back.
               if (pre_cnt_q == 3'(PREAMBLE_LEN)) begin
                  txd_q    <= SFD_BYTE;
                  tready_q <= 1'b1;
                  state_q  <= ST_PAYLOAD;
               end else begin
                  txd_q     <= PREAMBLE_BYTE;
                  pre_cnt_q <= pre_cnt_q + 3'd1;
               end
            end
            ST_PAYLOAD: begin
               if (s_axis_tvalid) begin
                  txd_q      <= s_axis_tdata;
                  crc_q      <= crc_d;
                  byte_cnt_q <= byte_cnt_d;
                  if (s_axis_tlast) begin
                     tready_q <= 1'b0;
                     if (s_axis_tuser) begin
                        tx_er_q   <= 1'b1;
                        state_q   <= ST_IFG;
                        ifg_cnt_q <= ifg_load_d;
                     end else if ((ENABLE_PADDING != 0) && (byte_cnt_d < PAD_TARGET)) begin
                        state_q <= ST_PAD;
                     end else begin
                        state_q   <= ST_FCS;
                        fcs_idx_q <= 2'd0;
                     end
                  end
               end else begin
                  txd_q   <= 8'h00;
                  tx_er_q <= 1'b1;
                  uf_q    <= 1'b1;
                  state_q <= ST_DRAIN;
               end
            end
            ST_PAD: begin
               txd_q      <= 8'h00;
               crc_q      <= crc_d;
               byte_cnt_q <= byte_cnt_d;
               if (byte_cnt_d >= PAD_TARGET) begin
                  state_q   <= ST_FCS;
                  fcs_idx_q <= 2'd0;
               end
            end
            ST_FCS: begin
               txd_q     <= fcs_byte;
               fcs_idx_q <= fcs_idx_q + 2'd1;
               if (fcs_idx_q == 2'd3) begin
                  sent_q    <= 1'b1;
                  state_q   <= ST_IFG;
                  ifg_cnt_q <= ifg_load_d;
               end
            end
            ST_IFG: begin
               tx_en_q  <= 1'b0;
               txd_q    <= 8'h00;
               tready_q <= 1'b0;
               if (ifg_cnt_q <= 8'd1) begin
                  state_q <= ST_IDLE;
               end else begin
                  ifg_cnt_q <= ifg_cnt_q - 8'd1;
               end
            end
            ST_DRAIN: begin
               tx_en_q <= 1'b0;
               txd_q   <= 8'h00;
               if (s_axis_tvalid && s_axis_tlast) begin
                  tready_q  <= 1'b0;
                  state_q   <= ST_IFG;
                  ifg_cnt_q <= ifg_load_d;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_axis_tready     = tready_q;
   assign gmii_txd          = txd_q;
   assign gmii_tx_en        = tx_en_q;
   assign gmii_tx_er        = tx_er_q;
   assign status_frame_sent = sent_q;
   assign status_underflow  = uf_q;

endmodule

// File: tb/tb_gmii_link_partner_tx.sv
// tb/tb_gmii_link_partner_tx.sv - self-checking bench for gmii_link_partner_tx
// Frames are rebuilt from first principles and compared against the captured GMII stream.
module tb_gmii_link_partner_tx;

   localparam int MINLEN = 64;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic       en;
      logic       er;
      logic       sent;
      logic       uf;
      logic [7:0] d;
   } mon_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] s_axis_tdata = 8'h00;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic       s_axis_tlast = 1'b0;
   logic       s_axis_tuser = 1'b0;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic [7:0] ifg_delay = 8'd12;
   logic       status_frame_sent;
   logic       status_underflow;

   int   checks = 0;
   int   errors = 0;
   bit   drv_abort = 1'b0;
   mon_t mlog[$];

   gmii_link_partner_tx #(
      .ENABLE_PADDING   (1),
      .MIN_FRAME_LENGTH (MINLEN)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tready     (s_axis_tready),
      .s_axis_tlast      (s_axis_tlast),
      .s_axis_tuser      (s_axis_tuser),
      .gmii_txd          (gmii_txd),
      .gmii_tx_en        (gmii_tx_en),
      .gmii_tx_er        (gmii_tx_er),
      .ifg_delay         (ifg_delay),
      .status_frame_sent (status_frame_sent),
      .status_underflow  (status_underflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) mlog.push_back({gmii_tx_en, gmii_tx_er, status_frame_sent, status_underflow, gmii_txd});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Non-reflected, MSB-first shift register fed with wire-order bits.
   function automatic logic [31:0] crc_normal(input byte_q_t q);
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[31] ^ q[i][b];
            c  = c << 1;
            if (fb) c = c ^ 32'h04C11DB7;
         end
      end
      return c;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   task automatic make_payload(input int n, input bit ramp, output byte_q_t q);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
   endtask

   task automatic send_frame(input byte_q_t pl, input bit abort, input int uf_at);
      int i = 0;
      int budget = 0;
      bit hs;
      bit uf_done = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pl[0];
      s_axis_tlast  = (pl.size() == 1);
      s_axis_tuser  = abort && (pl.size() == 1);
      while (i < pl.size() && !drv_abort) begin
         hs = s_axis_tready && s_axis_tvalid;
         @(posedge clk);
         #1;
         budget++;
         if (budget > 3000) begin
            checks++;
            errors++;
            $error("FAIL drv_timeout: observed %0d accepted expected %0d", i, pl.size());
            break;
         end
         if (hs) begin
            i++;
            if (i < pl.size()) begin
               s_axis_tdata = pl[i];
               s_axis_tlast = (i == pl.size() - 1);
               s_axis_tuser = abort && (i == pl.size() - 1);
            end
         end
         if (i == uf_at && !uf_done && i < pl.size()) begin
            s_axis_tvalid = 1'b0;
            uf_done = 1'b1;
         end else if (i < pl.size()) begin
            s_axis_tvalid = 1'b1;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic find_run(input int from, output int st, output int len);
      st  = -1;
      len = 0;
      for (int i = from; i < mlog.size(); i++) begin
         if (mlog[i].en) begin
            st = i;
            break;
         end
      end
      if (st >= 0) while (st + len < mlog.size() && mlog[st+len].en) len++;
   endtask

   task automatic count_flags(input int from, input int to, output int ns, output int nu, output int ne);
      ns = 0; nu = 0; ne = 0;
      for (int i = from; i < to && i < mlog.size(); i++) begin
         ns += int'(mlog[i].sent);
         nu += int'(mlog[i].uf);
         ne += int'(mlog[i].er);
      end
   endtask

   // Checks a complete, good frame: preamble, payload, zero pad, FCS, one sent pulse on the last byte.
   task automatic check_frame(input string tag, input int st, input int len, input byte_q_t pl);
      byte_q_t     body, exp, rx;
      logic [31:0] fcs;
      int          bad, ns, nu, ne;
      body = pl;
      while (body.size() < MINLEN - 4) body.push_back(8'h00);
      fcs = ~bitrev32(crc_normal(body));
      exp = {};
      for (int i = 0; i < 7; i++) exp.push_back(8'h55);
      exp.push_back(8'hD5);
      foreach (body[i]) exp.push_back(body[i]);
      for (int i = 0; i < 4; i++) exp.push_back(fcs[8*i +: 8]);
      chk({tag, ".start_found"}, 32'(st >= 0), 32'd1);
      chk({tag, ".len"}, len, exp.size());
      bad = 0;
      rx = {};
      if (st >= 0) begin
         for (int i = 0; i < len && i < exp.size(); i++) begin
            if (mlog[st+i].d !== exp[i]) bad++;
            if (i >= 8) rx.push_back(mlog[st+i].d);
         end
         chk({tag, ".byte_mismatches"}, bad, 0);
         chk({tag, ".residue"}, bitrev32(crc_normal(rx)), 32'hDEBB20E3);
         count_flags(st, st + len, ns, nu, ne);
         chk({tag, ".sent_pulses"}, ns, 1);
         chk({tag, ".sent_on_last"}, 32'(mlog[st+len-1].sent), 32'd1);
         chk({tag, ".tx_er_count"}, ne, 0);
         chk({tag, ".underflow_pulses"}, nu, 0);
      end
   endtask

   initial begin
      byte_q_t pa, pb;
      int base, st, len, st2, len2, ns, nu, ne, n, cyc, exp_gap;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.tready", 32'(s_axis_tready), 32'd0);
      chk("rst.tx_en", 32'(gmii_tx_en), 32'd0);
      chk("rst.tx_er", 32'(gmii_tx_er), 32'd0);
      chk("rst.txd", 32'(gmii_txd), 32'd0);
      chk("rst.status", 32'({status_frame_sent, status_underflow}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle.tready", 32'(s_axis_tready), 32'd0);
      chk("idle.tx_en", 32'(gmii_tx_en), 32'd0);

      // 60-byte ramp frame, ifg 12, followed back to back by a random frame
      @(posedge clk); #1;
      ifg_delay = 8'd12;
      base = mlog.size();
      make_payload(60, 1'b1, pa);
      make_payload($urandom_range(1, 90), 1'b0, pb);
      send_frame(pa, 1'b0, -1);
      send_frame(pb, 1'b0, -1);
      repeat (120) @(posedge clk);
      find_run(base, st, len);
      check_frame("ramp60", st, len, pa);
      find_run(st + len, st2, len2);
      chk("ramp60.ifg_gap", st2 - (st + len), 12);
      check_frame("ramp60.next", st2, len2, pb);

      // 10-byte frame padded up to the minimum size
      #1;
      base = mlog.size();
      make_payload(10, 1'b0, pa);
      send_frame(pa, 1'b0, -1);
      repeat (100) @(posedge clk);
      find_run(base, st, len);
      chk("pad10.tx_en_cycles", len, 72);
      check_frame("pad10", st, len, pa);

      // Underflow after payload byte 20
      #1;
      base = mlog.size();
      make_payload(40, 1'b0, pa);
      send_frame(pa, 1'b0, 20);
      repeat (60) @(posedge clk);
      find_run(base, st, len);
      chk("uf.len", len, 8 + 20 + 1);
      if (st >= 0) begin
         chk("uf.last_er", 32'(mlog[st+len-1].er), 32'd1);
         chk("uf.last_txd", 32'(mlog[st+len-1].d), 32'h00);
         chk("uf.pulse_on_err", 32'(mlog[st+len-1].uf), 32'd1);
         chk("uf.byte20", 32'(mlog[st+len-2].d), 32'(pa[19]));
      end
      count_flags(base, mlog.size(), ns, nu, ne);
      chk("uf.pulses", nu, 1);
      chk("uf.sent_pulses", ns, 0);
      chk("uf.er_count", ne, 1);
      find_run(st + len, st2, len2);
      chk("uf.no_more_tx", st2, -1);

      // Abort with tuser on byte 30
      #1;
      base = mlog.size();
      make_payload(30, 1'b0, pa);
      send_frame(pa, 1'b1, -1);
      repeat (60) @(posedge clk);
      find_run(base, st, len);
      chk("abort.len", len, 38);
      if (st >= 0) begin
         chk("abort.last_er", 32'(mlog[st+len-1].er), 32'd1);
         chk("abort.last_txd", 32'(mlog[st+len-1].d), 32'(pa[29]));
         chk("abort.sfd", 32'(mlog[st+7].d), 32'hD5);
      end
      count_flags(base, mlog.size(), ns, nu, ne);
      chk("abort.sent_pulses", ns, 0);
      chk("abort.uf_pulses", nu, 0);
      chk("abort.er_count", ne, 1);

      // Reset asserted while payload byte 15 is on the wire
      #1;
      base = mlog.size();
      make_payload(40, 1'b0, pa);
      drv_abort = 1'b0;
      fork
         send_frame(pa, 1'b0, -1);
         begin
            n = 0;
            cyc = 0;
            while (n < 8 + 15 && cyc < 500) begin
               @(negedge clk);
               if (gmii_tx_en) n++;
               cyc++;
            end
            chk("rstmid.reached_byte15", n, 23);
            #1 rst_n = 1'b0;
            #1;
            chk("rstmid.tx_en", 32'(gmii_tx_en), 32'd0);
            chk("rstmid.tx_er", 32'(gmii_tx_er), 32'd0);
            chk("rstmid.txd", 32'(gmii_txd), 32'd0);
            chk("rstmid.tready", 32'(s_axis_tready), 32'd0);
            drv_abort = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      drv_abort = 1'b0;
      find_run(base, st, len);
      chk("rstmid.truncated_len", len, 23);
      count_flags(base, mlog.size(), ns, nu, ne);
      chk("rstmid.sent_pulses", ns, 0);
      base = mlog.size();
      make_payload($urandom_range(20, 70), 1'b0, pa);
      send_frame(pa, 1'b0, -1);
      repeat (100) @(posedge clk);
      find_run(base, st, len);
      check_frame("after_rst", st, len, pa);

      // Back-to-back frames over a range of IFG settings, including 0
      for (int r = 0; r < 4; r++) begin
         #1;
         ifg_delay = (r == 0) ? 8'd0 : 8'($urandom_range(0, 15));
         exp_gap = (ifg_delay == 8'd0) ? 1 : int'(ifg_delay);
         base = mlog.size();
         make_payload($urandom_range(1, 80), 1'b0, pa);
         make_payload($urandom_range(1, 80), 1'b0, pb);
         send_frame(pa, 1'b0, -1);
         send_frame(pb, 1'b0, -1);
         repeat (120) @(posedge clk);
         find_run(base, st, len);
         check_frame($sformatf("b2b%0d.a", r), st, len, pa);
         find_run(st + len, st2, len2);
         chk($sformatf("b2b%0d.gap", r), st2 - (st + len), exp_gap);
         check_frame($sformatf("b2b%0d.b", r), st2, len2, pb);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gmii_link_partner_tx.md
Name: gmii_link_partner_tx

Overview:
- Link-partner transmitter. Takes an 8-bit AXI-Stream frame and drives a GMII transmit byte stream: preamble, SFD, payload, optional zero padding, FCS and inter-frame gap.
- Provides the far-end source that feeds our 1G MAC receive path, for loopback rigs and PHY-side emulation.
- Single clock domain, one byte per cycle, registered GMII outputs.

Parameters:
- ENABLE_PADDING, 1, pad payload with 0x00 up to MIN_FRAME_LENGTH-4 bytes before FCS.
- MIN_FRAME_LENGTH, 64, minimum frame length including FCS; legal range 5..1518.

Ports:
- clk  in  1  transmit byte clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted when tvalid&tready.
- s_axis_tlast  in  1  last payload byte.
- s_axis_tuser  in  1  abort flag, sampled with tlast.
- gmii_txd  out  8  GMII data.
- gmii_tx_en  out  1  GMII enable.
- gmii_tx_er  out  1  GMII error.
- ifg_delay  in  8  minimum idle cycles between frames, sampled on entry to IFG.
- status_frame_sent  out  1  one-cycle pulse, frame completed with valid FCS.
- status_underflow  out  1  one-cycle pulse, tvalid dropped mid-payload.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async assert, sync deassert by the caller): all outputs 0, state IDLE, counters 0, CRC 0xFFFFFFFF. Reset mid-frame truncates the frame immediately; no FCS is emitted.
- States: IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IFG, DRAIN.
- IDLE: tready=0. When tvalid=1 → PREAMBLE. The first preamble byte appears on GMII on the next cycle.
- PREAMBLE: 7 cycles of 0x55 then 1 cycle of 0xD5, all with tx_en=1. Then → PAYLOAD.
  - tready rises in the SFD cycle, so the first payload byte is on gmii_txd in the cycle after SFD.
- PAYLOAD: tready=1. An accepted byte appears on gmii_txd the next cycle, tx_en=1, and updates the CRC.
  - Byte counter: 16 bits, saturating.
  - tlast&!tuser: if ENABLE_PADDING and count < MIN_FRAME_LENGTH-4 → PAD, else → FCS.
  - tlast&tuser (abort): last byte is sent with tx_er=1, no FCS, → IFG. No status pulse.
  - tvalid=0 (underflow): next cycle drives tx_en=1, tx_er=1, txd=0x00; pulse status_underflow; → DRAIN.
- PAD: tready=0. Send 0x00 with CRC update until count = MIN_FRAME_LENGTH-4, then → FCS.
- FCS: 4 bytes of ~CRC, LSB byte first. CRC-32 is reflected, poly 0x04C11DB7, init 0xFFFFFFFF. Pulse status_frame_sent on the 4th FCS byte; → IFG.
- DRAIN: tready=1, tx_en=0. Discard input through tlast, then → IFG.
- IFG: tx_en=0, txd=0. Count max(ifg_delay,1) cycles, then → IDLE. Input is ignored.
- Simultaneous underflow and tlast cannot occur, since tlast requires tvalid.
- Byte counter and CRC clear on entry to PREAMBLE.

Optional Feature:
- Macro GMII_LINK_PARTNER_FCS_ERR_INJECT_EN.
- Defined: adds input inject_fcs_err (1 bit), sampled on the tlast handshake. When it is 1, FCS byte 0 is sent bit-inverted and status_frame_sent still pulses.
- Undefined: the port does not exist and the FCS is always correct.

Decomposition:
- Package gmii_link_pkg:
  - state enum;
  - constants PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, PREAMBLE_LEN 7;
  - CRC32_POLY, CRC32_INIT 0xFFFFFFFF, CRC32_RESIDUE 0xDEBB20E3.
- Sub-module crc32_byte_step: purely combinational 8-bit update of a 32-bit reflected CRC, shared with a future checker.

Test Plan:
- Single 60-byte frame 0x00..0x3B with ifg_delay=12 → 0x55×7, 0xD5, 60 payload bytes, FCS with CRC residue 0xDEBB20E3 over payload+FCS, frame_sent pulse once, then exactly 12 idle cycles.
- 10-byte frame, ENABLE_PADDING=1 → 50 zero pad bytes; tx_en high for 8+60+4=72 cycles.
- tvalid deasserted after payload byte 20 → one cycle tx_er=1 txd=0x00, underflow pulse, remaining bytes through tlast dropped, no FCS.
- tlast with tuser=1 on byte 30 → byte 30 sent with tx_er=1, no FCS, no frame_sent pulse.
- rst_n asserted during PAYLOAD byte 15 → tx_en/tx_er/txd/tready go 0 that instant; after release the next frame starts with a clean preamble and a correct FCS.
- Back-to-back frames with ifg_delay=0 → exactly 1 idle cycle between FCS byte 3 and the next preamble.
